// File: rtl/wb_rrbus_if.sv
// rtl/wb_rrbus_if.sv - port bundle of the round-robin Wishbone shared-bus interconnect
interface wb_rrbus_if #(
  parameter int nmasters = 4,
  parameter int nslaves  = 5
);
  logic [32*nmasters-1:0] m_adr_i;
  logic [32*nmasters-1:0] m_dat_i;
  logic [4*nmasters-1:0]  m_sel_i;
  logic [3*nmasters-1:0]  m_cti_i;
  logic [nmasters-1:0]    m_we_i;
  logic [nmasters-1:0]    m_cyc_i;
  logic [nmasters-1:0]    m_stb_i;
  logic [31:0]            m_dat_o;
  logic [nmasters-1:0]    m_ack_o;
  logic [nmasters-1:0]    m_err_o;
  logic [31:0]            s_adr_o;
  logic [31:0]            s_dat_o;
  logic [3:0]             s_sel_o;
  logic [2:0]             s_cti_o;
  logic                   s_we_o;
  logic [nslaves-1:0]     s_cyc_o;
  logic [nslaves-1:0]     s_stb_o;
  logic [32*nslaves-1:0]  s_dat_i;
  logic [nslaves-1:0]     s_ack_i;
  logic [2:0]             gnt_o;
  logic                   gnt_valid_o;

  // Interconnect view: requests and slave responses in, routed signals out
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o,
    output gnt_o, gnt_valid_o
  );

  // Attached-agent view: the masters and slaves hanging off the bus
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o,
    input  gnt_o, gnt_valid_o
  );
endinterface

// File: rtl/wb_rrbus.sv
// rtl/wb_rrbus.sv - round-robin Wishbone shared bus with unmapped-address and watchdog errors
module wb_rrbus #(
  parameter int nmasters  = 4,
  parameter int nslaves   = 5,
  parameter int s_addr_w  = 3,
  parameter logic [nslaves*s_addr_w-1:0] s_addr = {3'b101, 3'b100, 3'b010, 3'b001, 3'b000},
  parameter int timeout   = 1023,
  parameter int timeout_w = 10
) (
  input  logic      sys_clk,
  input  logic      sys_rst,
  wb_rrbus_if.slave bus
);

  // Watchdog count at which the error is raised on the following edge
  localparam logic [timeout_w-1:0] wd_last = timeout_w'(timeout > 0 ? timeout - 1 : 0);

  logic [2:0]           gnt, gnt_nxt;
  logic                 gnt_valid, gnt_valid_nxt;
  logic [timeout_w-1:0] wd, wd_nxt;
  logic                 err_r, err_nxt;
  logic                 own_valid, own_cyc, own_stb, own_we;
  logic [31:0]          own_adr, own_dat;
  logic [3:0]           own_sel;
  logic [2:0]           own_cti;
  logic                 hit, sel_ack, arb;
  logic [2:0]           sel_slave;
  logic [31:0]          sel_dat;

  // Reset hides the owner combinationally so slaves never see a cycle during reset
  assign own_valid = gnt_valid & ~sys_rst;

  // Select the current owner's request; everything reads as zero without an owner
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_cti = '0;
    for (int i = 0; i < nmasters; i++) begin
      if (own_valid && gnt == 3'(i)) begin
        own_cyc = bus.m_cyc_i[i];
        own_stb = bus.m_stb_i[i];
        own_we  = bus.m_we_i[i];
        own_adr = bus.m_adr_i[32*i +: 32];
        own_dat = bus.m_dat_i[32*i +: 32];
        own_sel = bus.m_sel_i[4*i +: 4];
        own_cti = bus.m_cti_i[3*i +: 3];
      end
    end
  end

  // Address decode (lowest matching slave wins) and return-path selection
  always_comb begin
    hit       = 1'b0;
    sel_slave = '0;
    sel_ack   = 1'b0;
    sel_dat   = '0;
    for (int k = nslaves - 1; k >= 0; k--) begin
      if (own_valid && own_adr[31 -: s_addr_w] == s_addr[k*s_addr_w +: s_addr_w]) begin
        hit       = 1'b1;
        sel_slave = 3'(k);
      end
    end
    for (int k = 0; k < nslaves; k++) begin
      if (hit && sel_slave == 3'(k)) begin
        sel_ack = bus.s_ack_i[k];
        sel_dat = bus.s_dat_i[32*k +: 32];
      end
    end
  end

  // Drive the shared slave bus and route responses back to the owner only
  always_comb begin
    bus.s_adr_o = own_adr;
    bus.s_dat_o = own_dat;
    bus.s_sel_o = own_sel;
    bus.s_cti_o = own_cti;
    bus.s_we_o  = own_we;
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    for (int k = 0; k < nslaves; k++) begin
      if (hit && !err_r && sel_slave == 3'(k)) begin
        bus.s_cyc_o[k] = own_cyc;
        bus.s_stb_o[k] = own_stb;
      end
    end
    bus.m_dat_o = sel_dat;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    for (int i = 0; i < nmasters; i++) begin
      if (gnt == 3'(i)) begin
        bus.m_ack_o[i] = sel_ack;
        bus.m_err_o[i] = err_r;
      end
    end
    bus.gnt_o       = gnt;
    bus.gnt_valid_o = gnt_valid;
  end

  // Round-robin: once the owner releases cyc, pick the requester closest after it
  always_comb begin
    int off;
    int best;
    off           = 0;
    best          = nmasters;
    arb           = !own_cyc;
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    if (arb) begin
      gnt_valid_nxt = 1'b0;
      for (int j = 0; j < nmasters; j++) begin
        // The current owner lands at distance nmasters-1, so it is picked only when alone
        off = (j - int'(gnt) - 1 + 2 * nmasters) % nmasters;
        if (bus.m_cyc_i[j] && off < best) begin
          best          = off;
          gnt_nxt       = 3'(j);
          gnt_valid_nxt = 1'b1;
        end
      end
    end
  end

  // Error pulse for unmapped or stalled accesses; an ack on the limit edge wins
  always_comb begin
    err_nxt = 1'b0;
    wd_nxt  = '0;
    if (!err_r && own_stb) begin
      if (!hit) begin
        err_nxt = 1'b1;
      end else if (timeout != 0 && !sel_ack && wd == wd_last) begin
        err_nxt = 1'b1;
      end
    end
    if (timeout != 0 && !arb && own_stb && hit && !sel_ack && !err_r) begin
      wd_nxt = wd + timeout_w'(1);
    end
  end

  // State registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      wd        <= '0;
      err_r     <= 1'b0;
    end else begin
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      wd        <= wd_nxt;
      err_r     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rrbus.sv
// tb/tb_wb_rrbus.sv - self-checking bench for wb_rrbus against a cycle reference model
module tb_wb_rrbus;
  localparam int NM = 4;
  localparam int NS = 5;
  localparam int TO = 8;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  wb_rrbus_if #(.nmasters(NM), .nslaves(NS)) bus ();

  wb_rrbus #(
    .nmasters(NM), .nslaves(NS), .s_addr_w(3),
    .s_addr({3'b101, 3'b100, 3'b010, 3'b001, 3'b000}),
    .timeout(TO), .timeout_w(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  // Stimulus state
  logic [31:0] madr[NM], mdat[NM];
  logic [3:0]  msel[NM];
  logic [2:0]  mcti[NM];
  logic        mwe[NM], mcyc[NM], mstb[NM];
  logic [31:0] sdat[NS];
  logic        sack[NS];

  // Address region (top 3 bits) -> slave number, -1 = hole in the map
  int region_slave[8] = '{0, 1, 2, -1, 3, 4, -1, -1};

  // Reference model: who owns the bus, how long the access has gone unanswered
  int m_own = 0;
  bit m_valid = 0;
  int m_pend = 0;
  bit m_err = 0;

  // Per-cycle view shared between look() and adv()
  bit e_ov, e_c, e_s, e_ack;
  int e_slv;
  logic [31:0] e_adr;

  int n_checks = 0;
  int n_errors = 0;
  string phase = "init";
  int exp_order[4] = '{0, 1, 2, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NM; k++) begin
      bus.m_adr_i[32*k +: 32] = madr[k];
      bus.m_dat_i[32*k +: 32] = mdat[k];
      bus.m_sel_i[4*k +: 4]   = msel[k];
      bus.m_cti_i[3*k +: 3]   = mcti[k];
      bus.m_we_i[k]           = mwe[k];
      bus.m_cyc_i[k]          = mcyc[k];
      bus.m_stb_i[k]          = mstb[k];
    end
    for (int s = 0; s < NS; s++) begin
      bus.s_dat_i[32*s +: 32] = sdat[s];
      bus.s_ack_i[s]          = sack[s];
    end
  endtask

  // Apply inputs and compare every output with the model for this cycle
  task automatic look();
    drive();
    #1;
    e_ov  = m_valid && !sys_rst;
    e_adr = e_ov ? madr[m_own] : 32'h0;
    e_c   = e_ov && mcyc[m_own];
    e_s   = e_ov && mstb[m_own];
    e_slv = e_ov ? region_slave[e_adr[31:29]] : -1;
    e_ack = 1'b0;
    if (e_slv >= 0) e_ack = sack[e_slv];
    chk("gnt_valid", 32'(bus.gnt_valid_o), 32'(m_valid));
    chk("gnt", 32'(bus.gnt_o), 32'(m_own));
    chk("s_cyc", 32'(bus.s_cyc_o), (e_slv >= 0 && !m_err && e_c) ? (32'd1 << e_slv) : 32'd0);
    chk("s_stb", 32'(bus.s_stb_o), (e_slv >= 0 && !m_err && e_s) ? (32'd1 << e_slv) : 32'd0);
    chk("m_dat", bus.m_dat_o, (e_slv >= 0) ? sdat[e_slv] : 32'd0);
    chk("m_ack", 32'(bus.m_ack_o), e_ack ? (32'd1 << m_own) : 32'd0);
    chk("m_err", 32'(bus.m_err_o), m_err ? (32'd1 << m_own) : 32'd0);
    chk("s_adr", bus.s_adr_o, e_adr);
    chk("s_dat", bus.s_dat_o, e_ov ? mdat[m_own] : 32'd0);
    chk("s_sel", 32'(bus.s_sel_o), e_ov ? 32'(msel[m_own]) : 32'd0);
    chk("s_cti", 32'(bus.s_cti_o), e_ov ? 32'(mcti[m_own]) : 32'd0);
    chk("s_we", 32'(bus.s_we_o), 32'(e_ov && mwe[m_own]));
  endtask

  // Advance the model across the clock edge, then move to the next cycle
  task automatic adv();
    bit nerr;
    int npend;
    if (sys_rst) begin
      m_own = 0; m_valid = 0; m_pend = 0; m_err = 0;
    end else begin
      nerr = 0;
      if (!m_err && e_s) begin
        if (e_slv < 0) nerr = 1;
        else if (!e_ack && m_pend + 1 == TO) nerr = 1;
      end
      npend = (e_s && e_slv >= 0 && !e_ack && !m_err && e_c) ? m_pend + 1 : 0;
      if (!e_c) begin
        m_valid = 0;
        for (int d = 1; d <= NM; d++) begin
          if (mcyc[(m_own + d) % NM]) begin
            m_own = (m_own + d) % NM;
            m_valid = 1;
            break;
          end
        end
      end
      m_err = nerr;
      m_pend = npend;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic step();
    look();
    adv();
  endtask

  task automatic idle_all();
    for (int k = 0; k < NM; k++) begin
      mcyc[k] = 0; mstb[k] = 0; mcti[k] = 0;
    end
    for (int s = 0; s < NS; s++) sack[s] = 0;
  endtask

  initial begin
    for (int k = 0; k < NM; k++) begin
      madr[k] = 0; mdat[k] = 32'h1000 + k; msel[k] = 4'hf; mcti[k] = 0;
      mwe[k] = 0; mcyc[k] = 0; mstb[k] = 0;
    end
    for (int s = 0; s < NS; s++) begin
      sdat[s] = 32'hA000 + s; sack[s] = 0;
    end
    sys_rst = 1'b1;
    drive();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    phase = "reset";
    look();
    chk("gnt_rst", 32'(bus.gnt_o), 32'd0);
    chk("scyc_rst", 32'(bus.s_cyc_o), 32'd0);
    chk("merr_rst", 32'(bus.m_err_o), 32'd0);
    adv();

    phase = "single";
    mcyc[1] = 1; mstb[1] = 1; madr[1] = 32'h2000_0010; mwe[1] = 0;
    look(); chk("gv_t0", 32'(bus.gnt_valid_o), 32'd0); adv();
    look(); chk("gv_t1", 32'(bus.gnt_valid_o), 32'd1); chk("gnt_t1", 32'(bus.gnt_o), 32'd1); adv();
    step();
    sack[1] = 1; sdat[1] = 32'hDEAD_BEEF;
    look(); chk("dat", bus.m_dat_o, 32'hDEAD_BEEF); chk("ack", 32'(bus.m_ack_o), 32'b0010); adv();
    idle_all(); step(); step();

    phase = "rr";
    mcyc[2] = 1; mstb[2] = 1; madr[2] = 32'h0000_0100;
    step();
    mcyc[2] = 0; mstb[2] = 0;
    step();
    look(); chk("gnt_start", 32'(bus.gnt_o), 32'd2); adv();
    sack[0] = 1;
    for (int k = 0; k < 3; k++) madr[k] = 32'h0000_0000 + 4 * k;
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 3; k++) begin
        mcyc[k] = (t != 2 * k + 2);
        mstb[k] = mcyc[k];
      end
      look();
      if (t % 2 == 1) begin
        chk("order", 32'(bus.gnt_o), 32'(exp_order[t / 2]));
        chk("order_v", 32'(bus.gnt_valid_o), 32'd1);
      end
      adv();
    end
    idle_all(); step(); step();

    phase = "burst";
    mcyc[0] = 1; mstb[0] = 1; mcti[0] = 3'b010; madr[0] = 32'h4000_0000;
    step();
    mcyc[1] = 1; mstb[1] = 1; madr[1] = 32'h2000_0000; sack[2] = 1;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) mcti[0] = 3'b111;
      look(); chk("hold", 32'(bus.gnt_o), 32'd0); adv();
    end
    mcyc[0] = 0; mstb[0] = 0; mcti[0] = 0; sack[2] = 0;
    look(); chk("hold_drop", 32'(bus.gnt_o), 32'd0); adv();
    look(); chk("handover", 32'(bus.gnt_o), 32'd1); chk("handover_v", 32'(bus.gnt_valid_o), 32'd1); adv();
    idle_all(); step(); step();

    phase = "unmapped";
    mcyc[0] = 1; mstb[0] = 1; madr[0] = 32'h6000_0000;
    step();
    look(); chk("no_cyc", 32'(bus.s_cyc_o), 32'd0); chk("err_early", 32'(bus.m_err_o), 32'd0); adv();
    look(); chk("err", 32'(bus.m_err_o), 32'b0001); chk("no_cyc_err", 32'(bus.s_cyc_o), 32'd0); adv();
    look(); chk("err_once", 32'(bus.m_err_o), 32'd0); adv();
    idle_all(); step(); step(); step();

    phase = "wd_timeout";
    mcyc[0] = 1; mstb[0] = 1; madr[0] = 32'h4000_0010;
    step();
    for (int c = 0; c < 9; c++) begin
      look();
      if (c == 7) chk("err_before", 32'(bus.m_err_o), 32'd0);
      if (c == 8) begin
        chk("err_wd", 32'(bus.m_err_o), 32'b0001);
        chk("stb_forced", 32'(bus.s_stb_o), 32'd0);
      end
      adv();
    end
    idle_all(); step(); step();

    phase = "wd_ack";
    mcyc[0] = 1; mstb[0] = 1; madr[0] = 32'h4000_0020;
    step();
    for (int c = 0; c < 9; c++) begin
      sack[2] = (c == 7);
      if (c == 8) begin mcyc[0] = 0; mstb[0] = 0; end
      look();
      if (c == 7) chk("ack_limit", 32'(bus.m_ack_o), 32'b0001);
      if (c == 8) chk("no_err", 32'(bus.m_err_o), 32'd0);
      adv();
    end
    idle_all(); step(); step();

    phase = "rst_burst";
    mcyc[3] = 1; mstb[3] = 1; mcti[3] = 3'b010; madr[3] = 32'h8000_0000;
    sack[3] = 1; sdat[3] = $urandom;
    step();
    step();
    sys_rst = 1'b1;
    look(); chk("rst_scyc", 32'(bus.s_cyc_o), 32'd0); chk("rst_sstb", 32'(bus.s_stb_o), 32'd0); adv();
    sys_rst = 1'b0;
    look();
    chk("post_v", 32'(bus.gnt_valid_o), 32'd0);
    chk("post_scyc", 32'(bus.s_cyc_o), 32'd0);
    chk("post_ack", 32'(bus.m_ack_o), 32'd0);
    chk("post_dat", bus.m_dat_o, 32'd0);
    adv();
    idle_all(); step(); step();

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      sys_rst = ($urandom_range(99) == 0);
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(3) == 0) mcyc[k] = ~mcyc[k];
        mstb[k] = mcyc[k] & 1'($urandom_range(1));
        madr[k] = {3'($urandom_range(7)), 29'($urandom)};
        mdat[k] = $urandom;
        msel[k] = 4'($urandom);
        mcti[k] = 3'($urandom);
        mwe[k]  = 1'($urandom);
      end
      for (int s = 0; s < NS; s++) begin
        sdat[s] = $urandom;
        sack[s] = ($urandom_range(5) == 0);
      end
      step();
    end
    sys_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
